// File: rtl/imm_decode_pipe.sv
// imm_decode_pipe: RISC-V immediate decoder behind a 2-entry skid buffer.
// The instruction class and extended immediate are computed combinationally
// from the incoming word and captured into a main/skid register pair, so a
// result appears one cycle after acceptance and back-pressure never loses data.
// Optional feature: define RVC_IMM_EN to decode compressed (16-bit) immediates;
// without it every compressed encoding decodes as NONE.
module imm_decode_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_type,
  output logic [TAG_W-1:0] out_tag
);

  typedef enum logic [2:0] {
    IMM_I    = 3'd0,
    IMM_S    = 3'd1,
    IMM_B    = 3'd2,
    IMM_J    = 3'd3,
    IMM_U    = 3'd4,
    IMM_Z    = 3'd5,
    IMM_C    = 3'd6,
    IMM_NONE = 3'd7
  } immType_e;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpOpImm  = 7'b0010011;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpImm32  = 7'b0011011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpSystem = 7'b1110011;

  immType_e         decType;
  logic [31:0]      decImm32;
  logic [XLEN-1:0]  decImm;

  logic             mainValid_q, mainValid_d;
  logic [XLEN-1:0]  mainImm_q, mainImm_d;
  immType_e         mainType_q, mainType_d;
  logic [TAG_W-1:0] mainTag_q, mainTag_d;

  logic             skidValid_q, skidValid_d;
  logic [XLEN-1:0]  skidImm_q, skidImm_d;
  immType_e         skidType_q, skidType_d;
  logic [TAG_W-1:0] skidTag_q, skidTag_d;

  logic             inReady_q, inReady_d;
  logic             inFire;
  logic             outFire;

`ifdef RVC_IMM_EN
  immType_e    rvcType;
  logic [31:0] rvcImm32;

  // Compressed immediates: quadrant in [1:0], funct3 in [15:13]; unsupported encodings give NONE.
  always_comb begin
    rvcType  = IMM_NONE;
    rvcImm32 = '0;
    case (in_instr[1:0])
      2'b00: begin
        case (in_instr[15:13])
          3'b000: begin
            rvcType  = IMM_C;
            rvcImm32 = {22'b0, in_instr[10:7], in_instr[12:11], in_instr[5], in_instr[6], 2'b00};
          end
          3'b010, 3'b110: begin
            rvcType  = IMM_C;
            rvcImm32 = {25'b0, in_instr[5], in_instr[12:10], in_instr[6], 2'b00};
          end
          default: ;
        endcase
      end
      2'b01: begin
        case (in_instr[15:13])
          3'b000, 3'b010: begin
            rvcType  = IMM_C;
            rvcImm32 = {{26{in_instr[12]}}, in_instr[12], in_instr[6:2]};
          end
          3'b001: begin
            if (XLEN == 32) begin
              rvcType  = IMM_C;
              rvcImm32 = {{20{in_instr[12]}}, in_instr[12], in_instr[8], in_instr[10:9], in_instr[6],
                          in_instr[7], in_instr[2], in_instr[11], in_instr[5:3], 1'b0};
            end
          end
          3'b011: begin
            rvcType = IMM_C;
            if (in_instr[11:7] == 5'd2) begin
              rvcImm32 = {{22{in_instr[12]}}, in_instr[12], in_instr[4:3], in_instr[5], in_instr[2],
                          in_instr[6], 4'b0};
            end else begin
              rvcImm32 = {{14{in_instr[12]}}, in_instr[12], in_instr[6:2], 12'b0};
            end
          end
          3'b101: begin
            rvcType  = IMM_C;
            rvcImm32 = {{20{in_instr[12]}}, in_instr[12], in_instr[8], in_instr[10:9], in_instr[6],
                        in_instr[7], in_instr[2], in_instr[11], in_instr[5:3], 1'b0};
          end
          3'b110, 3'b111: begin
            rvcType  = IMM_C;
            rvcImm32 = {{23{in_instr[12]}}, in_instr[12], in_instr[6:5], in_instr[2], in_instr[11:10],
                        in_instr[4:3], 1'b0};
          end
          default: ;
        endcase
      end
      2'b10: begin
        case (in_instr[15:13])
          3'b010: begin
            rvcType  = IMM_C;
            rvcImm32 = {24'b0, in_instr[3:2], in_instr[12], in_instr[6:4], 2'b00};
          end
          3'b110: begin
            rvcType  = IMM_C;
            rvcImm32 = {24'b0, in_instr[8:7], in_instr[12:9], 2'b00};
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end
`endif

  // Classify the 32-bit opcode and assemble its immediate as a 32-bit value.
  always_comb begin
    decType  = IMM_NONE;
    decImm32 = '0;
    case (in_instr[6:0])
      OpLoad, OpOpImm, OpJalr, OpImm32: begin
        decType  = IMM_I;
        decImm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      OpStore: begin
        decType  = IMM_S;
        decImm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      OpBranch: begin
        decType  = IMM_B;
        decImm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
      end
      OpJal: begin
        decType  = IMM_J;
        decImm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
      end
      OpLui, OpAuipc: begin
        decType  = IMM_U;
        decImm32 = {in_instr[31:12], 12'b0};
      end
      OpSystem: begin
        if (in_instr[14]) begin
          decType  = IMM_Z;
          decImm32 = {27'b0, in_instr[19:15]};
        end else begin
          decType  = IMM_I;
          decImm32 = {{20{in_instr[31]}}, in_instr[31:20]};
        end
      end
      default: ;
    endcase
`ifdef RVC_IMM_EN
    if (in_instr[1:0] != 2'b11) begin
      decType  = rvcType;
      decImm32 = rvcImm32;
    end
`endif
  end

  // Zero-extended classes keep bit 31 clear, so one sign extension serves every class.
  if (XLEN > 32) begin : gWide
    assign decImm = {{(XLEN-32){decImm32[31]}}, decImm32};
  end else begin : gNarrow
    assign decImm = decImm32;
  end

  assign inFire  = in_valid && inReady_q;
  assign outFire = mainValid_q && out_ready;

  // Skid buffer next state: main refills from skid on drain, new data lands in skid only when main is stuck.
  always_comb begin
    mainValid_d = mainValid_q;
    mainImm_d   = mainImm_q;
    mainType_d  = mainType_q;
    mainTag_d   = mainTag_q;
    skidValid_d = skidValid_q;
    skidImm_d   = skidImm_q;
    skidType_d  = skidType_q;
    skidTag_d   = skidTag_q;
    if (outFire) begin
      if (skidValid_q) begin
        mainImm_d   = skidImm_q;
        mainType_d  = skidType_q;
        mainTag_d   = skidTag_q;
        skidValid_d = 1'b0;
      end else if (inFire) begin
        mainImm_d  = decImm;
        mainType_d = decType;
        mainTag_d  = in_tag;
      end else begin
        mainValid_d = 1'b0;
      end
    end else if (inFire) begin
      if (!mainValid_q) begin
        mainValid_d = 1'b1;
        mainImm_d   = decImm;
        mainType_d  = decType;
        mainTag_d   = in_tag;
      end else begin
        skidValid_d = 1'b1;
        skidImm_d   = decImm;
        skidType_d  = decType;
        skidTag_d   = in_tag;
      end
    end
    inReady_d = !skidValid_d;
  end

  // State registers with synchronous reset that discards both entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      mainValid_q <= 1'b0;
      mainImm_q   <= '0;
      mainType_q  <= IMM_NONE;
      mainTag_q   <= '0;
      skidValid_q <= 1'b0;
      skidImm_q   <= '0;
      skidType_q  <= IMM_NONE;
      skidTag_q   <= '0;
      inReady_q   <= 1'b1;
    end else begin
      mainValid_q <= mainValid_d;
      mainImm_q   <= mainImm_d;
      mainType_q  <= mainType_d;
      mainTag_q   <= mainTag_d;
      skidValid_q <= skidValid_d;
      skidImm_q   <= skidImm_d;
      skidType_q  <= skidType_d;
      skidTag_q   <= skidTag_d;
      inReady_q   <= inReady_d;
    end
  end

  assign in_ready  = inReady_q;
  assign out_valid = mainValid_q;
  assign out_imm   = mainImm_q;
  assign out_type  = mainType_q;
  assign out_tag   = mainTag_q;

endmodule

// File: tb/tb_imm_decode_pipe.sv
// Testbench for imm_decode_pipe: directed cases followed by randomized traffic
// scored against an arithmetic decode model and a 2-deep FIFO occupancy model.
module tb_imm_decode_pipe;

  localparam int XLEN  = 32;
  localparam int TAG_W = 8;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [2:0]       out_type;
  logic [TAG_W-1:0] out_tag;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [2:0]       typ;
    logic [TAG_W-1:0] tag;
  } entry_t;

  entry_t sb[$];
  int     checks = 0;
  int     passes = 0;

  imm_decode_pipe #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_instr (in_instr),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_imm  (out_imm),
    .out_type (out_type),
    .out_tag  (out_tag)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  // Drive one cycle of inputs, then return at the following falling edge.
  task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic [TAG_W-1:0] tag,
                               input logic rdy);
    in_valid  = v;
    in_instr  = instr;
    in_tag    = tag;
    out_ready = rdy;
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [XLEN-1:0] sx(input longint v);
    logic [63:0] t;
    t = v;
    return t[XLEN-1:0];
  endfunction

  function automatic longint fld(input longint w, input int lo, input int n);
    return (w >> lo) & ((longint'(1) << n) - 1);
  endfunction

  // Reference decode computed from field values with integer arithmetic.
  task automatic refDecode(input logic [31:0] ins, output logic [XLEN-1:0] imm, output logic [2:0] typ);
    longint w, v, s, op, f3;
    int     t;
    w  = longint'(ins);
    v  = 0;
    t  = 7;
    op = fld(w, 0, 7);
    s  = fld(w, 31, 1);
    f3 = fld(w, 12, 3);
    if (op == 'h03 || op == 'h13 || op == 'h67 || op == 'h1B || (op == 'h73 && f3 < 4)) begin
      t = 0; v = fld(w, 20, 12) - s * 4096;
    end else if (op == 'h23) begin
      t = 1; v = fld(w, 25, 7) * 32 + fld(w, 7, 5) - s * 4096;
    end else if (op == 'h63) begin
      t = 2; v = fld(w, 7, 1) * 2048 + fld(w, 25, 6) * 32 + fld(w, 8, 4) * 2 - s * 4096;
    end else if (op == 'h6F) begin
      t = 3; v = fld(w, 12, 8) * 4096 + fld(w, 20, 1) * 2048 + fld(w, 21, 10) * 2 - s * (longint'(1) << 20);
    end else if (op == 'h37 || op == 'h17) begin
      t = 4; v = fld(w, 12, 20) * 4096 - s * (longint'(1) << 32);
    end else if (op == 'h73) begin
      t = 5; v = fld(w, 15, 5);
    end
`ifdef RVC_IMM_EN
    if (fld(w, 0, 2) != 3) begin
      longint q, c3, cs;
      q  = fld(w, 0, 2);
      c3 = fld(w, 13, 3);
      cs = fld(w, 12, 1);
      t  = 6;
      v  = 0;
      if (q == 0 && c3 == 0)
        v = fld(w, 7, 4) * 64 + fld(w, 11, 2) * 16 + fld(w, 5, 1) * 8 + fld(w, 6, 1) * 4;
      else if (q == 0 && (c3 == 2 || c3 == 6))
        v = fld(w, 5, 1) * 64 + fld(w, 10, 3) * 8 + fld(w, 6, 1) * 4;
      else if (q == 1 && (c3 == 0 || c3 == 2))
        v = fld(w, 2, 5) - cs * 32;
      else if (q == 1 && c3 == 3 && fld(w, 7, 5) == 2)
        v = fld(w, 3, 2) * 128 + fld(w, 5, 1) * 64 + fld(w, 2, 1) * 32 + fld(w, 6, 1) * 16 - cs * 512;
      else if (q == 1 && c3 == 3)
        v = (fld(w, 2, 5) - cs * 32) * 4096;
      else if (q == 1 && (c3 == 5 || (c3 == 1 && XLEN == 32)))
        v = fld(w, 8, 1) * 1024 + fld(w, 9, 2) * 256 + fld(w, 6, 1) * 128 + fld(w, 7, 1) * 64 +
            fld(w, 2, 1) * 32 + fld(w, 11, 1) * 16 + fld(w, 3, 3) * 2 - cs * 2048;
      else if (q == 1 && c3 >= 6)
        v = fld(w, 5, 2) * 64 + fld(w, 2, 1) * 32 + fld(w, 10, 2) * 8 + fld(w, 3, 2) * 2 - cs * 256;
      else if (q == 2 && c3 == 2)
        v = fld(w, 2, 2) * 64 + fld(w, 12, 1) * 32 + fld(w, 4, 3) * 4;
      else if (q == 2 && c3 == 6)
        v = fld(w, 7, 2) * 64 + fld(w, 9, 4) * 4;
      else
        t = 7;
    end
`endif
    imm = sx(v);
    typ = 3'(t);
  endtask

  task automatic genInstr(output logic [31:0] ins);
    logic [6:0]  ops [10];
    logic [31:0] r;
    logic [1:0]  q;
    int          kind;
    ops  = '{7'h03, 7'h13, 7'h67, 7'h1B, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17, 7'h73};
    kind = $urandom_range(0, 12);
    r    = $urandom;
    q    = 2'($urandom_range(0, 2));
    if (kind < 10) ins = {r[31:7], ops[kind]};
    else if (kind == 10) ins = r;
    else ins = {r[31:2], q};
  endtask

  task automatic resetDut();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("rst_out_imm", 64'(out_imm), 64'd0);
    checkOutput("rst_out_type", 64'(out_type), 64'd7);
    checkOutput("rst_out_tag", 64'(out_tag), 64'd0);
    rst = 1'b0;
    sb.delete();
  endtask

  // Directed cases, then randomized traffic against the reference model.
  initial begin
    entry_t          e;
    logic [31:0]     ins, holdInstr;
    logic [TAG_W-1:0] tg, holdTag;
    logic            v, rdy, holdV, inF, outF;
    int              pct;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_instr  = '0;
    in_tag    = '0;
    out_ready = 1'b0;
    @(negedge clk);
    resetDut();

    applyStimulus(1'b1, 32'hFFF00093, 8'h01, 1'b1);
    checkOutput("addi_valid", 64'(out_valid), 64'd1);
    checkOutput("addi_imm", 64'(out_imm), 64'(sx(-1)));
    checkOutput("addi_type", 64'(out_type), 64'd0);

    applyStimulus(1'b1, 32'hFE112E23, 8'h02, 1'b1);
    checkOutput("b2b_sw_imm", 64'(out_imm), 64'(sx(-4)));
    checkOutput("b2b_sw_type", 64'(out_type), 64'd1);
    applyStimulus(1'b1, 32'h123452B7, 8'h03, 1'b1);
    checkOutput("b2b_lui_valid", 64'(out_valid), 64'd1);
    checkOutput("b2b_lui_imm", 64'(out_imm), 64'(sx(64'h12345000)));
    checkOutput("b2b_lui_type", 64'(out_type), 64'd4);
    applyStimulus(1'b1, 32'hFF9FF06F, 8'h04, 1'b1);
    checkOutput("b2b_j_imm", 64'(out_imm), 64'(sx(-8)));
    checkOutput("b2b_j_type", 64'(out_type), 64'd3);
    checkOutput("b2b_j_tag", 64'(out_tag), 64'h04);
    applyStimulus(1'b0, 32'h0, 8'h00, 1'b1);
    checkOutput("b2b_drained", 64'(out_valid), 64'd0);

    applyStimulus(1'b1, 32'hFFF00093, 8'hA1, 1'b0);
    checkOutput("bp1_in_ready", 64'(in_ready), 64'd1);
    checkOutput("bp1_tag", 64'(out_tag), 64'hA1);
    applyStimulus(1'b1, 32'hFE112E23, 8'hB2, 1'b0);
    checkOutput("bp2_in_ready", 64'(in_ready), 64'd0);
    checkOutput("bp2_tag", 64'(out_tag), 64'hA1);
    applyStimulus(1'b1, 32'h123452B7, 8'hC3, 1'b0);
    checkOutput("bp3_in_ready", 64'(in_ready), 64'd0);
    checkOutput("bp3_imm_stable", 64'(out_imm), 64'(sx(-1)));
    checkOutput("bp3_tag_stable", 64'(out_tag), 64'hA1);
    applyStimulus(1'b1, 32'h123452B7, 8'hC3, 1'b1);
    checkOutput("bp4_tag", 64'(out_tag), 64'hB2);
    checkOutput("bp4_type", 64'(out_type), 64'd1);
    checkOutput("bp4_in_ready", 64'(in_ready), 64'd1);
    applyStimulus(1'b1, 32'h123452B7, 8'hC3, 1'b1);
    checkOutput("bp5_tag", 64'(out_tag), 64'hC3);
    checkOutput("bp5_type", 64'(out_type), 64'd4);
    applyStimulus(1'b0, 32'h0, 8'h00, 1'b1);
    checkOutput("bp6_drained", 64'(out_valid), 64'd0);

    applyStimulus(1'b1, 32'h0000557D, 8'h5C, 1'b1);
`ifdef RVC_IMM_EN
    checkOutput("cli_imm", 64'(out_imm), 64'(sx(-1)));
    checkOutput("cli_type", 64'(out_type), 64'd6);
`else
    checkOutput("cli_imm", 64'(out_imm), 64'd0);
    checkOutput("cli_type", 64'(out_type), 64'd7);
`endif
    applyStimulus(1'b0, 32'h0, 8'h00, 1'b1);

    applyStimulus(1'b1, 32'hFFF00093, 8'h11, 1'b0);
    applyStimulus(1'b1, 32'hFE112E23, 8'h22, 1'b0);
    checkOutput("mid_full_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 8'h00, 1'b1);
    checkOutput("mid_rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("mid_rst_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 32'h0, 8'h00, 1'b1);
      checkOutput("mid_rst_no_stale", 64'(out_valid), 64'd0);
    end

    resetDut();
    holdV     = 1'b0;
    holdInstr = '0;
    holdTag   = '0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      checkOutput("rnd_out_valid", 64'(out_valid), 64'(sb.size() > 0));
      checkOutput("rnd_in_ready", 64'(in_ready), 64'(sb.size() < 2));
      if (sb.size() > 0) begin
        checkOutput("rnd_imm", 64'(out_imm), 64'(sb[0].imm));
        checkOutput("rnd_type", 64'(out_type), 64'(sb[0].typ));
        checkOutput("rnd_tag", 64'(out_tag), 64'(sb[0].tag));
      end
      pct = (cyc < 200) ? 90 : (cyc < 400) ? 50 : (cyc < 600) ? 20 : 100;
      rdy = ($urandom_range(0, 99) < pct);
      if (holdV) begin
        v   = 1'b1;
        ins = holdInstr;
        tg  = holdTag;
      end else begin
        v = ($urandom_range(0, 3) != 0);
        genInstr(ins);
        tg = TAG_W'($urandom);
      end
      inF  = v && (sb.size() < 2);
      outF = rdy && (sb.size() > 0);
      applyStimulus(v, ins, tg, rdy);
      if (outF) void'(sb.pop_front());
      if (inF) begin
        refDecode(ins, e.imm, e.typ);
        e.tag = tg;
        sb.push_back(e);
      end
      holdV     = v && !inF;
      holdInstr = ins;
      holdTag   = tg;
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/imm_decode_pipe.md
IMM_DECODE_PIPE -- requirements
Module: imm_decode_pipe

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the immediate output width; legal values are 32 and 64.
REQ-002 The block SHALL have parameter TAG_W, default 8, giving the width of an opaque sideband tag carried with each instruction.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: an input instruction is presented.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts input this cycle.
REQ-007 The block SHALL have port in_instr, input, 32 bits: the full instruction word, opcode included.
REQ-008 The block SHALL have port in_tag, input, TAG_W bits: sideband data, passed through unchanged.
REQ-009 The block SHALL have port out_valid, output, 1 bit: a decoded result is presented.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-011 The block SHALL have port out_imm, output, XLEN bits: the extended immediate.
REQ-012 The block SHALL have port out_type, output, 3 bits: immediate class, with I=0, S=1, B=2, J=3, U=4, Z=5, C=6, NONE=7.
REQ-013 The block SHALL have port out_tag, output, TAG_W bits: the tag of the presented result.

Function
REQ-014 Class SHALL be derived from opcode in_instr[6:0] with no external immsrc:
- LOAD, OP-IMM, JALR, OP-IMM-32: I.
- STORE: S.
- BRANCH: B.
- JAL: J.
- LUI, AUIPC: U.
- SYSTEM with funct3[2]=1: Z.
- SYSTEM otherwise: I.
- Anything else: NONE.
REQ-015 I, S, B and J immediates SHALL be sign-extended from in_instr[31] to XLEN bits, using standard RV field placement; B and J have bit0=0.
REQ-016 U SHALL be {instr[31:12],12'b0}, sign-extended to XLEN.
REQ-017 Z SHALL be zero-extended instr[19:15].
REQ-018 NONE SHALL give out_imm=0.
REQ-019 Input SHALL transfer when in_valid&&in_ready; output SHALL transfer when out_valid&&out_ready.
REQ-020 Latency SHALL be exactly 1 cycle from input transfer to out_valid, with sustained throughput of one instruction per cycle when out_ready=1.
REQ-021 Storage SHALL be a 2-entry skid buffer (main + skid); in_ready SHALL be a registered signal equal to "skid entry empty".
REQ-022 When out_valid=1 and out_ready=0, out_imm, out_type and out_tag SHALL hold stable until transfer.
REQ-023 On an input transfer while main is full and not draining, the entry SHALL go to skid and in_ready SHALL drop the next cycle.
REQ-024 When main drains, skid SHALL move to main in the same cycle and in_ready SHALL rise the next cycle.
REQ-025 Simultaneous input and output transfer with one entry held SHALL keep occupancy at 1, with no bubble.
REQ-026 Order SHALL be preserved; no entry SHALL be dropped or duplicated.
REQ-027 in_valid while in_ready=0 SHALL be ignored, and the producer SHALL hold the instruction.

Reset
REQ-028 While rst=1, at the next clk edge: out_valid=0, both entries empty, in_ready=1.
REQ-029 out_imm, out_type and out_tag SHALL reset to 0, 7 and 0.
REQ-030 Reset asserted mid-operation SHALL discard all held entries; no output transfer SHALL occur in the reset cycle.

Configuration
REQ-031 Macro RVC_IMM_EN:
- When defined, instructions with in_instr[1:0]!=2'b11 SHALL decode as class C, covering C.ADDI4SPN, C.LW, C.SW, C.ADDI, C.LI, C.LUI, C.ADDI16SP, C.J, C.JAL (XLEN=32 only), C.BEQZ, C.BNEZ, C.LWSP and C.SWSP.
- In that mode the immediate SHALL be scaled and sign- or zero-extended per the RVC specification.
- Other compressed encodings SHALL give NONE.
- When undefined, all compressed encodings SHALL give NONE with out_imm=0, and the RVC decode logic SHALL be absent.

Verification
REQ-032 Bench case: in_instr 0xFFF00093 (addi x1,x0,-1), XLEN=32 -> out_imm 0xFFFFFFFF, out_type 0; with XLEN=64 -> out_imm 0xFFFFFFFFFFFFFFFF.
REQ-033 Bench case: back-to-back 0xFE112E23 (sw -4), 0x123452B7 (lui 0x12345) and 0xFF9FF06F (j -8), out_ready=1 -> the following in consecutive cycles, one cycle after each input:
- 0xFFFFFFFC, type 1.
- 0x12345000, type 4.
- 0xFFFFFFF8, type 3.
REQ-034 Bench case: out_ready=0 with 3 inputs offered -> 2 accepted and in_ready=0 from cycle 2; outputs stable; after out_ready=1, results emerge in order with tags intact.
REQ-035 Bench case: 0x557D (c.li x10,-1) -> with RVC_IMM_EN: 0xFFFFFFFF, type 6; without: 0, type 7.
REQ-036 Bench case: rst=1 pulsed while 2 entries are held -> next cycle out_valid=0, in_ready=1, and no stale result thereafter.
